program_loader: RTL

- Upstream feeder for CPU_4bit: receives a program as a byte stream over a valid/ready handshake and writes it into the CPU's instruction memory through a write port.
- Holds the CPU in reset for the whole load and releases it only after a length and checksum check passes.
- A `start` pulse re-arms it for a reload without a global reset.

---
 rtl/program_loader.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// program_loader
// Receives a program as a byte stream (LEN, N instruction bytes, CHK) over a
// valid/ready handshake and writes it into the CPU instruction memory. The
// CPU is held in reset for the whole load and released only once the length
// is legal and the checksum (8-bit sum of the instruction bytes) matches.
// A start pulse in DONE or ERROR re-arms the loader without a global reset.
//
// Handshake: a byte transfers on a rising edge where rx_valid && rx_ready.
// rx_ready is registered and depends only on state, never on rx_valid, so
// the sender may hold or drop rx_valid at will; a low rx_valid is a bubble.
//
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   start        one-cycle re-arm pulse (honoured only in DONE / ERROR)
//   rx_data      incoming stream byte
//   rx_valid     rx_data valid
//   rx_ready     loader accepts a byte this cycle
//   imem_we      one-cycle write pulse per instruction byte
//   imem_addr    write address
//   imem_wdata   write data
//   cpu_reset    CPU reset, low only in DONE
//   load_done    high while in DONE
//   load_error   high while in ERROR
//   fsm_state    current FSM state (IDLE=0 LOAD=1 CHECK=2 DONE=3 ERROR=4)
module program_loader #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [7:0]        imem_wdata,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_error,
  output logic [2:0]        fsm_state
);

  // One extra bit so the counter and stored length can represent DEPTH itself.
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [7:0] DEPTH_B = 8'(DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] len;
  logic [CNT_W-1:0] count;
  logic [7:0]       sum;
  logic             accept;

  assign accept    = rx_valid && rx_ready;
  assign fsm_state = state;

  // rx_ready, cpu_reset, load_done and load_error are registered alongside
  // the state transition, so each one already reflects the state being
  // entered on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rx_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_reset  <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
      len        <= '0;
      count      <= '0;
      sum        <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        IDLE: begin
          rx_ready <= 1'b1;
          if (accept) begin
            if (rx_data != 8'd0 && rx_data <= DEPTH_B) begin
              len   <= rx_data[CNT_W-1:0];
              count <= '0;
              sum   <= '0;
              state <= LOAD;
            end else begin
              state      <= ERROR;
              rx_ready   <= 1'b0;
              load_error <= 1'b1;
            end
          end
        end

        LOAD: begin
          if (accept) begin
            imem_we    <= 1'b1;
            imem_addr  <= count[ADDR_W-1:0];
            imem_wdata <= rx_data;
            sum        <= sum + rx_data;
            count      <= count + CNT_W'(1);
            if (count + CNT_W'(1) == len) begin
              state <= CHECK;
            end
          end
        end

        CHECK: begin
          if (accept) begin
            rx_ready <= 1'b0;
            if (rx_data == sum) begin
              state     <= DONE;
              cpu_reset <= 1'b0;
              load_done <= 1'b1;
            end else begin
              state      <= ERROR;
              load_error <= 1'b1;
            end
          end
        end

        DONE, ERROR: begin
          // rx_ready is already low here, so a byte presented together with
          // start is never consumed.
          if (start) begin
            state      <= IDLE;
            rx_ready   <= 1'b1;
            cpu_reset  <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
          end
        end

        default: begin
          state      <= IDLE;
          rx_ready   <= 1'b0;
          cpu_reset  <= 1'b1;
          load_done  <= 1'b0;
          load_error <= 1'b0;
        end
      endcase
    end
  end

endmodule
